// File: rtl/lpc_io_target_pkg.sv
// -----------------------------------------------------------------------------
// lpc_io_target_pkg
// Shared definitions for the LPC I/O target: the protocol FSM state encoding,
// the LAD nibble constants used on the bus, and a small helper that checks
// whether a 16-bit I/O address falls inside the claimed window.
// -----------------------------------------------------------------------------
package lpc_io_target_pkg;

   // Protocol FSM states
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_CYCTYPE = 4'd1,
      ST_ADDR    = 4'd2,
      ST_WDATA   = 4'd3,
      ST_TAR_H   = 4'd4,
      ST_SYNC    = 4'd5,
      ST_RDATA   = 4'd6,
      ST_TAR_T   = 4'd7,
      ST_IGNORE  = 4'd8
   } lpc_state_e;

   // LAD nibble values
   localparam logic [3:0] LAD_START  = 4'b0000;
   localparam logic [3:0] LAD_IDLE   = 4'b1111;
   localparam logic [1:0] CYC_IO     = 2'b00;
   localparam logic [3:0] CYC_IO_RD  = 4'b0000;
   localparam logic [3:0] CYC_IO_WR  = 4'b0010;
   localparam logic [3:0] SYNC_READY = 4'b0000;
   localparam logic [3:0] SYNC_LWAIT = 4'b0110;
   localparam logic [3:0] SYNC_ERR   = 4'b1010;

   // Address window test done in 17 bits so BASE+SPAN cannot wrap at 0xFFFF.
   function automatic logic addr_in_window(input logic [15:0] addr,
                                           input logic [16:0] lo,
                                           input logic [16:0] hi);
      logic [16:0] a17;
      a17 = {1'b0, addr};
      return (a17 >= lo) && (a17 < hi);
   endfunction

endpackage : lpc_io_target_pkg

// File: rtl/lpc_nibble_shift.sv
// -----------------------------------------------------------------------------
// lpc_nibble_shift
// 16-bit nibble shift register with a nibble count, used by the LPC target to
// collect both the address nibbles and the write-data nibbles.
//
// Ports
//   clk       in   clock (rising edge)
//   rst       in   asynchronous active-high reset
//   clear     in   synchronous clear of value and count (wins over shift_en)
//   shift_en  in   shift nib_in into the low nibble this cycle
//   nib_in    in   nibble to shift in
//   shifted   out  look-ahead value {stored[11:0], nib_in}, i.e. the contents
//                  including the nibble presented this cycle
//   count     out  number of nibbles shifted since the last clear
// -----------------------------------------------------------------------------
module lpc_nibble_shift (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [3:0]  nib_in,
   output logic [15:0] shifted,
   output logic [2:0]  count
);

   logic [15:0] value_r;
   logic [2:0]  count_r;

   // Look-ahead lets the FSM decide on the last nibble in the same cycle.
   assign shifted = {value_r[11:0], nib_in};
   assign count   = count_r;

   // Shift register and nibble counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_r <= 16'h0000;
         count_r <= 3'd0;
      end else if (clear) begin
         value_r <= 16'h0000;
         count_r <= 3'd0;
      end else if (shift_en) begin
         value_r <= shifted;
         count_r <= (count_r == 3'd7) ? count_r : count_r + 3'd1;
      end else begin
         value_r <= value_r;
         count_r <= count_r;
      end
   end

endmodule : lpc_nibble_shift

// File: rtl/lpc_io_target.sv
// -----------------------------------------------------------------------------
// lpc_io_target
// LPC bus I/O target that claims ADDR_SPAN consecutive I/O ports starting at
// BASE_ADDR and bridges them to a simple UART-style register interface.
// Long-wait SYNC is inserted while the register file is not ready; after
// MAX_WAIT long-wait cycles an error SYNC is returned instead.
//
// Ports
//   lpc_clk    in   LPC clock, all logic on the rising edge
//   lpc_rst    in   asynchronous active-high reset
//   lpc_ad_in  in   LAD[3:0] sampled from the bus
//   lpc_ad_out out  LAD[3:0] driven by this target (registered)
//   lpc_ad_oe  out  output enable for lpc_ad_out (registered)
//   lpc_frame  in   LFRAME#, active low
//   reg_addr   out  register offset, address bits [2:0]
//   reg_wdata  out  register write data
//   reg_wr     out  one-cycle write strobe (first TAR cycle)
//   reg_rd     out  one-cycle read strobe (first TAR cycle)
//   reg_rdata  in   register read data, valid while reg_ready is high
//   reg_ready  in   register access complete
// -----------------------------------------------------------------------------
module lpc_io_target
   import lpc_io_target_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h03F8,
   parameter int          ADDR_SPAN = 8,
   parameter int          MAX_WAIT  = 8
) (
   input  logic       lpc_clk,
   input  logic       lpc_rst,
   input  logic [3:0] lpc_ad_in,
   output logic [3:0] lpc_ad_out,
   output logic       lpc_ad_oe,
   input  logic       lpc_frame,
   output logic [2:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   input  logic       reg_ready
);

   localparam int          WAIT_W  = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [16:0] ADDR_LO = {1'b0, BASE_ADDR};
   localparam logic [16:0] ADDR_HI = {1'b0, BASE_ADDR} + 17'(ADDR_SPAN);

   lpc_state_e        state_r,     state_s;
   logic              dir_wr_r,    dir_wr_s;
   logic              phase_r,     phase_s;
   logic [WAIT_W-1:0] wait_cnt_r,  wait_cnt_s;
   logic [7:0]        rdata_r,     rdata_s;
   logic [3:0]        ad_out_r,    ad_out_s;
   logic              ad_oe_r,     ad_oe_s;
   logic              reg_wr_r,    reg_wr_s;
   logic              reg_rd_r,    reg_rd_s;
   logic [2:0]        reg_addr_r,  reg_addr_s;
   logic [7:0]        reg_wdata_r, reg_wdata_s;

   logic              sh_clear_s;
   logic              sh_shift_s;
   logic [15:0]       sh_shifted_s;
   logic [2:0]        sh_count_s;
   logic              addr_hit_s;

   lpc_nibble_shift u_shift (
      .clk      (lpc_clk),
      .rst      (lpc_rst),
      .clear    (sh_clear_s),
      .shift_en (sh_shift_s),
      .nib_in   (lpc_ad_in),
      .shifted  (sh_shifted_s),
      .count    (sh_count_s)
   );

   assign addr_hit_s = addr_in_window(sh_shifted_s, ADDR_LO, ADDR_HI);

   assign lpc_ad_out = ad_out_r;
   assign lpc_ad_oe  = ad_oe_r;
   assign reg_addr   = reg_addr_r;
   assign reg_wdata  = reg_wdata_r;
   assign reg_wr     = reg_wr_r;
   assign reg_rd     = reg_rd_r;

   // Next-state and next-output logic; outputs are computed for the cycle
   // after the edge, so SYNC reflects reg_ready as sampled at that edge.
   always_comb begin
      state_s     = state_r;
      dir_wr_s    = dir_wr_r;
      phase_s     = 1'b0;
      wait_cnt_s  = wait_cnt_r;
      rdata_s     = rdata_r;
      ad_out_s    = LAD_IDLE;
      ad_oe_s     = 1'b0;
      reg_wr_s    = 1'b0;
      reg_rd_s    = 1'b0;
      reg_addr_s  = reg_addr_r;
      reg_wdata_s = reg_wdata_r;
      sh_clear_s  = 1'b0;
      sh_shift_s  = 1'b0;

      if (!lpc_frame) begin
         // LFRAME# asserted: new START or abort, from any state
         sh_clear_s = 1'b1;
         wait_cnt_s = '0;
         if (lpc_ad_in == LAD_START) begin
            state_s = ST_CYCTYPE;
         end else begin
            state_s = ST_IDLE;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_IDLE;
            end

            ST_CYCTYPE: begin
               if (lpc_ad_in[3:2] == CYC_IO) begin
                  dir_wr_s = lpc_ad_in[1];
                  state_s  = ST_ADDR;
               end else begin
                  state_s = ST_IGNORE;
               end
            end

            ST_ADDR: begin
               sh_shift_s = 1'b1;
               if (sh_count_s == 3'd3) begin
                  // Fourth nibble: decide claim; shifter is reused for data
                  sh_clear_s = 1'b1;
                  if (addr_hit_s) begin
                     reg_addr_s = sh_shifted_s[2:0];
                     if (dir_wr_r) begin
                        state_s = ST_WDATA;
                     end else begin
                        reg_rd_s = 1'b1;
                        state_s  = ST_TAR_H;
                     end
                  end else begin
                     state_s = ST_IGNORE;
                  end
               end else begin
                  state_s = ST_ADDR;
               end
            end

            ST_WDATA: begin
               sh_shift_s = 1'b1;
               if (sh_count_s == 3'd1) begin
                  // Data arrives low nibble first, so the byte is swapped
                  sh_clear_s  = 1'b1;
                  reg_wdata_s = {sh_shifted_s[3:0], sh_shifted_s[7:4]};
                  reg_wr_s    = 1'b1;
                  state_s     = ST_TAR_H;
               end else begin
                  state_s = ST_WDATA;
               end
            end

            ST_TAR_H: begin
               if (!phase_r) begin
                  phase_s = 1'b1;
                  state_s = ST_TAR_H;
               end else begin
                  state_s    = ST_SYNC;
                  ad_oe_s    = 1'b1;
                  wait_cnt_s = '0;
                  if (reg_ready) begin
                     ad_out_s = SYNC_READY;
                     rdata_s  = reg_rdata;
                  end else begin
                     ad_out_s   = SYNC_LWAIT;
                     wait_cnt_s = WAIT_W'(1);
                  end
               end
            end

            ST_SYNC: begin
               // The SYNC code currently on the bus tells which phase we are in
               ad_oe_s = 1'b1;
               if (ad_out_r == SYNC_READY) begin
                  if (dir_wr_r) begin
                     state_s = ST_TAR_T;
                  end else begin
                     ad_out_s = rdata_r[3:0];
                     state_s  = ST_RDATA;
                  end
               end else if (ad_out_r == SYNC_ERR) begin
                  state_s = ST_TAR_T;
               end else begin
                  state_s = ST_SYNC;
                  if (reg_ready) begin
                     ad_out_s = SYNC_READY;
                     rdata_s  = reg_rdata;
                  end else if (wait_cnt_r == WAIT_W'(MAX_WAIT)) begin
                     ad_out_s = SYNC_ERR;
                  end else begin
                     ad_out_s   = SYNC_LWAIT;
                     wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                  end
               end
            end

            ST_RDATA: begin
               ad_oe_s = 1'b1;
               if (!phase_r) begin
                  phase_s  = 1'b1;
                  ad_out_s = rdata_r[7:4];
                  state_s  = ST_RDATA;
               end else begin
                  state_s = ST_TAR_T;
               end
            end

            ST_TAR_T: begin
               wait_cnt_s = '0;
               if (!phase_r) begin
                  phase_s = 1'b1;
                  state_s = ST_TAR_T;
               end else begin
                  state_s = ST_IDLE;
               end
            end

            ST_IGNORE: begin
               state_s = ST_IGNORE;
            end

            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // State and registered outputs; reset releases the bus asynchronously
   always_ff @(posedge lpc_clk or posedge lpc_rst) begin
      if (lpc_rst) begin
         state_r     <= ST_IDLE;
         dir_wr_r    <= 1'b0;
         phase_r     <= 1'b0;
         wait_cnt_r  <= '0;
         rdata_r     <= 8'h00;
         ad_out_r    <= LAD_IDLE;
         ad_oe_r     <= 1'b0;
         reg_wr_r    <= 1'b0;
         reg_rd_r    <= 1'b0;
         reg_addr_r  <= 3'd0;
         reg_wdata_r <= 8'h00;
      end else begin
         state_r     <= state_s;
         dir_wr_r    <= dir_wr_s;
         phase_r     <= phase_s;
         wait_cnt_r  <= wait_cnt_s;
         rdata_r     <= rdata_s;
         ad_out_r    <= ad_out_s;
         ad_oe_r     <= ad_oe_s;
         reg_wr_r    <= reg_wr_s;
         reg_rd_r    <= reg_rd_s;
         reg_addr_r  <= reg_addr_s;
         reg_wdata_r <= reg_wdata_s;
      end
   end

endmodule : lpc_io_target

// File: tb/tb_lpc_io_target.sv
// -----------------------------------------------------------------------------
// tb_lpc_io_target
// Directed self-checking bench for lpc_io_target with default parameters.
// Inputs are applied before a rising edge; outputs are sampled 1 time unit
// after it.
// -----------------------------------------------------------------------------
module tb_lpc_io_target;

   logic       lpc_clk;
   logic       lpc_rst;
   logic [3:0] lpc_ad_in;
   logic [3:0] lpc_ad_out;
   logic       lpc_ad_oe;
   logic       lpc_frame;
   logic [2:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_rdata;
   logic       reg_ready;

   int n_vec  = 0;
   int n_miss = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int oe_cnt = 0;
   int wr0, rd0, oe0;

   lpc_io_target dut (
      .lpc_clk    (lpc_clk),
      .lpc_rst    (lpc_rst),
      .lpc_ad_in  (lpc_ad_in),
      .lpc_ad_out (lpc_ad_out),
      .lpc_ad_oe  (lpc_ad_oe),
      .lpc_frame  (lpc_frame),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_wr     (reg_wr),
      .reg_rd     (reg_rd),
      .reg_rdata  (reg_rdata),
      .reg_ready  (reg_ready)
   );

   initial lpc_clk = 1'b0;
   always #5 lpc_clk = ~lpc_clk;

   // Strobe and output-enable activity monitor
   always @(negedge lpc_clk) begin
      if (reg_wr)    wr_cnt <= wr_cnt + 1;
      if (reg_rd)    rd_cnt <= rd_cnt + 1;
      if (lpc_ad_oe) oe_cnt <= oe_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic fr, input logic [3:0] ad);
      lpc_frame = fr;
      lpc_ad_in = ad;
      @(posedge lpc_clk);
      #1;
   endtask

   // START, cycle type and four address nibbles (MSB first)
   task automatic send_hdr(input logic wr, input logic [15:0] a);
      tick(1'b0, 4'b0000);
      tick(1'b1, wr ? 4'b0010 : 4'b0000);
      for (int i = 3; i >= 0; i--) tick(1'b1, a[i*4 +: 4]);
   endtask

   initial begin
      lpc_rst   = 1'b1;
      lpc_frame = 1'b1;
      lpc_ad_in = 4'hF;
      reg_rdata = 8'h00;
      reg_ready = 1'b1;
      @(posedge lpc_clk);
      @(posedge lpc_clk);
      #1;
      // reset state
      check_val("rst_oe",    16'(lpc_ad_oe),  16'h0);
      check_val("rst_out",   16'(lpc_ad_out), 16'hF);
      check_val("rst_wr",    16'(reg_wr),     16'h0);
      check_val("rst_rd",    16'(reg_rd),     16'h0);
      check_val("rst_addr",  16'(reg_addr),   16'h0);
      check_val("rst_wdata", 16'(reg_wdata),  16'h00);
      lpc_rst = 1'b0;
      tick(1'b1, 4'hF);

      // write 0x03F8 <- 0xA5, ready high
      wr0 = wr_cnt;
      reg_ready = 1'b1;
      send_hdr(1'b1, 16'h03F8);
      check_val("w_wdata_oe", 16'(lpc_ad_oe), 16'h0);
      tick(1'b1, 4'h5);
      tick(1'b1, 4'hA);
      check_val("w_wr",    16'(reg_wr),    16'h1);
      check_val("w_addr",  16'(reg_addr),  16'h0);
      check_val("w_wdata", 16'(reg_wdata), 16'hA5);
      check_val("w_tarh_oe", 16'(lpc_ad_oe), 16'h0);
      tick(1'b1, 4'hF);
      check_val("w_tarh2_wr", 16'(reg_wr), 16'h0);
      check_val("w_tarh2_oe", 16'(lpc_ad_oe), 16'h0);
      tick(1'b1, 4'hF);
      check_val("w_sync",    16'(lpc_ad_out), 16'h0);
      check_val("w_sync_oe", 16'(lpc_ad_oe),  16'h1);
      tick(1'b1, 4'hF);
      check_val("w_tart",    16'(lpc_ad_out), 16'hF);
      check_val("w_tart_oe", 16'(lpc_ad_oe),  16'h1);
      tick(1'b1, 4'hF);
      check_val("w_tart2_oe", 16'(lpc_ad_oe), 16'h0);
      tick(1'b1, 4'hF);
      check_val("w_idle_oe", 16'(lpc_ad_oe), 16'h0);
      check_val("w_wr_count", 16'(wr_cnt - wr0), 16'd1);

      // read 0x03FD, three long waits, data 0x60
      rd0 = rd_cnt;
      reg_ready = 1'b0;
      reg_rdata = 8'h60;
      send_hdr(1'b0, 16'h03FD);
      check_val("r_rd",   16'(reg_rd),    16'h1);
      check_val("r_addr", 16'(reg_addr),  16'h5);
      check_val("r_oe",   16'(lpc_ad_oe), 16'h0);
      tick(1'b1, 4'hF);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 4'hF);
         check_val("r_lwait", 16'(lpc_ad_out), 16'h6);
      end
      reg_ready = 1'b1;
      tick(1'b1, 4'hF);
      check_val("r_sync",    16'(lpc_ad_out), 16'h0);
      check_val("r_sync_oe", 16'(lpc_ad_oe),  16'h1);
      reg_ready = 1'b0;
      reg_rdata = 8'hFF;
      tick(1'b1, 4'hF);
      check_val("r_data_lo", 16'(lpc_ad_out), 16'h0);
      tick(1'b1, 4'hF);
      check_val("r_data_hi", 16'(lpc_ad_out), 16'h6);
      tick(1'b1, 4'hF);
      check_val("r_tart", 16'(lpc_ad_out), 16'hF);
      check_val("r_tart_oe", 16'(lpc_ad_oe), 16'h1);
      tick(1'b1, 4'hF);
      check_val("r_tart2_oe", 16'(lpc_ad_oe), 16'h0);
      check_val("r_rd_count", 16'(rd_cnt - rd0), 16'd1);

      // unclaimed write to 0x02F8
      wr0 = wr_cnt; rd0 = rd_cnt; oe0 = oe_cnt;
      reg_ready = 1'b1;
      send_hdr(1'b1, 16'h02F8);
      tick(1'b1, 4'h5);
      tick(1'b1, 4'hA);
      for (int i = 0; i < 4; i++) tick(1'b1, 4'hF);
      check_val("ign_oe",  16'(oe_cnt - oe0), 16'd0);
      check_val("ign_str", 16'((wr_cnt - wr0) + (rd_cnt - rd0)), 16'd0);

      // read with ready stuck low: 8 long waits then error, no data phase
      reg_ready = 1'b0;
      send_hdr(1'b0, 16'h03F8);
      tick(1'b1, 4'hF);
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 4'hF);
         check_val("to_lwait", 16'(lpc_ad_out), 16'h6);
      end
      tick(1'b1, 4'hF);
      check_val("to_err",    16'(lpc_ad_out), 16'hA);
      check_val("to_err_oe", 16'(lpc_ad_oe),  16'h1);
      tick(1'b1, 4'hF);
      check_val("to_tart",    16'(lpc_ad_out), 16'hF);
      check_val("to_tart_oe", 16'(lpc_ad_oe),  16'h1);
      tick(1'b1, 4'hF);
      check_val("to_tart2_oe", 16'(lpc_ad_oe), 16'h0);

      // abort in 3rd address nibble, then write 0x03F9 <- 0x3C
      wr0 = wr_cnt;
      reg_ready = 1'b1;
      tick(1'b0, 4'h0);
      tick(1'b1, 4'h2);
      tick(1'b1, 4'h0);
      tick(1'b1, 4'h3);
      tick(1'b0, 4'hF);
      tick(1'b1, 4'hF);
      check_val("ab_nostrobe", 16'(wr_cnt - wr0), 16'd0);
      check_val("ab_oe", 16'(lpc_ad_oe), 16'h0);
      send_hdr(1'b1, 16'h03F9);
      tick(1'b1, 4'hC);
      tick(1'b1, 4'h3);
      check_val("ab_wr",    16'(reg_wr),    16'h1);
      check_val("ab_addr",  16'(reg_addr),  16'h1);
      check_val("ab_wdata", 16'(reg_wdata), 16'h3C);
      for (int i = 0; i < 4; i++) tick(1'b1, 4'hF);
      check_val("ab_wr_count", 16'(wr_cnt - wr0), 16'd1);

      // async reset during SYNC of a read, then a normal read
      reg_ready = 1'b0;
      send_hdr(1'b0, 16'h03F8);
      tick(1'b1, 4'hF);
      tick(1'b1, 4'hF);
      check_val("ar_sync_oe", 16'(lpc_ad_oe), 16'h1);
      #3;
      lpc_rst = 1'b1;
      #1;
      check_val("ar_oe",   16'(lpc_ad_oe),  16'h0);
      check_val("ar_out",  16'(lpc_ad_out), 16'hF);
      check_val("ar_addr", 16'(reg_addr),   16'h0);
      @(posedge lpc_clk);
      #1;
      lpc_rst = 1'b0;
      tick(1'b1, 4'hF);
      check_val("ar_idle_oe", 16'(lpc_ad_oe), 16'h0);
      reg_ready = 1'b1;
      reg_rdata = 8'h5A;
      send_hdr(1'b0, 16'h03FF);
      check_val("ar2_rd",   16'(reg_rd),   16'h1);
      check_val("ar2_addr", 16'(reg_addr), 16'h7);
      tick(1'b1, 4'hF);
      tick(1'b1, 4'hF);
      check_val("ar2_sync", 16'(lpc_ad_out), 16'h0);
      tick(1'b1, 4'hF);
      check_val("ar2_lo", 16'(lpc_ad_out), 16'hA);
      tick(1'b1, 4'hF);
      check_val("ar2_hi", 16'(lpc_ad_out), 16'h5);
      tick(1'b1, 4'hF);
      check_val("ar2_tart", 16'(lpc_ad_out), 16'hF);
      tick(1'b1, 4'hF);
      check_val("ar2_tart2_oe", 16'(lpc_ad_oe), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_lpc_io_target

// File: doc/lpc_io_target.md
LPC_IO_TARGET -- requirements
Module: lpc_io_target

Interface
REQ-001 Parameter BASE_ADDR, default 16'h03F8: first I/O address claimed.
REQ-002 Parameter ADDR_SPAN, default 8: number of consecutive I/O addresses claimed (power of two).
REQ-003 Parameter MAX_WAIT, default 8: maximum long-wait SYNC cycles before an error SYNC is sent.
REQ-004 lpc_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 lpc_rst  in  1  reset, asynchronous, active-high.
REQ-006 lpc_ad_in  in  4  LAD[3:0] as sampled from the bus.
REQ-007 lpc_ad_out  out  4  LAD[3:0] value driven by the target.
REQ-008 lpc_ad_oe  out  1  output enable for lpc_ad_out; the top level tristates LAD when this is low.
REQ-009 lpc_frame  in  1  LFRAME#, active-low cycle start/abort.
REQ-010 reg_addr  out  3  UART register offset (address bits [2:0]).
REQ-011 reg_wdata  out  8  write data to the UART register file.
REQ-012 reg_wr  out  1  one-cycle write strobe.
REQ-013 reg_rd  out  1  one-cycle read strobe.
REQ-014 reg_rdata  in  8  read data, valid while reg_ready is high.
REQ-015 reg_ready  in  1  register access complete; low inserts wait states.

Function
REQ-016 FSM states: IDLE, CYCTYPE, ADDR, WDATA, TAR_H, SYNC, RDATA, TAR_T, IGNORE.
REQ-017 In any state, lpc_frame low with lpc_ad_in 4'b0000 moves the FSM to CYCTYPE on the next edge; lpc_frame low with any other nibble moves it to IDLE; lpc_ad_oe deasserts in the same edge (abort).
REQ-018 CYCTYPE: lpc_ad_in[3:2]==2'b00 selects I/O, lpc_ad_in[1] gives direction (0 read, 1 write), next state ADDR; any other cycle type goes to IGNORE.
REQ-019 ADDR: four nibbles, MSB first, are shifted into a 16-bit address; after the 4th nibble a match (BASE_ADDR <= addr < BASE_ADDR+ADDR_SPAN) goes to WDATA (write) or TAR_H (read); a miss goes to IGNORE.
REQ-020 WDATA: two nibbles, low nibble first, form reg_wdata; next state TAR_H.
REQ-021 TAR_H: two cycles with lpc_ad_oe low; in the first cycle reg_addr is valid and exactly one of reg_wr or reg_rd pulses high for one cycle.
REQ-022 SYNC: lpc_ad_oe high; drive 4'b0110 (long wait) while reg_ready is low; drive 4'b0000 in the first cycle reg_ready is high (or was high at the end of TAR_H); capture reg_rdata in that cycle.
REQ-023 Wait counter: after MAX_WAIT consecutive 4'b0110 cycles, drive 4'b1010 (error) for one cycle, then go to TAR_T; for reads, skip RDATA.
REQ-024 After a 4'b0000 SYNC: reads go to RDATA, which drives the captured byte low nibble first over 2 cycles; writes go straight to TAR_T.
REQ-025 TAR_T: first cycle drives 4'b1111 with lpc_ad_oe high; second cycle lpc_ad_oe low; then IDLE.
REQ-026 IGNORE: lpc_ad_oe low, no strobes; exit only via the REQ-017 frame condition.
REQ-027 No strobe is issued for aborted, unclaimed or non-I/O cycles.
REQ-028 lpc_ad_oe is never high outside SYNC, RDATA and TAR_T cycle 1.

Reset
REQ-029 While lpc_rst is high: state IDLE, lpc_ad_oe=0, lpc_ad_out=4'b1111, reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0, wait counter=0.
REQ-030 Reset asserted mid-cycle releases the bus immediately (asynchronously); after release the block waits for a new START.

Structure
REQ-031 A shared package holds the FSM state enum and the LPC constants: START 4'b0000, CYCTYPE I/O read/write, SYNC_READY 4'b0000, SYNC_LWAIT 4'b0110, SYNC_ERR 4'b1010.
REQ-032 One sub-module, lpc_nibble_shift (a 16-bit nibble shift register with a count), serves both ADDR and WDATA capture; all else is flat.

Verification
REQ-033 I/O write to 0x03F8 with data 0xA5 and reg_ready tied high -> exactly one reg_wr pulse with reg_addr=0, reg_wdata=0xA5; SYNC 0000; TAR_T 1111; then bus released.
REQ-034 I/O read from 0x03FD, reg_ready low for 3 cycles, reg_rdata=0x60 -> SYNC 0110 x3, then 0000, RDATA nibbles 0 then 6, then TAR_T.
REQ-035 I/O write to 0x02F8 -> IGNORE; lpc_ad_oe stays low; no strobes.
REQ-036 Read with reg_ready stuck low -> 8 SYNC 0110 cycles, one 1010 cycle, no RDATA, then TAR_T.
REQ-037 lpc_frame low with nibble 1111 during the 3rd ADDR nibble, followed by a valid write to 0x03F9 -> first cycle produces no strobe; second cycle gives reg_addr=1.
REQ-038 lpc_rst asserted during SYNC of a read -> lpc_ad_oe drops without waiting for a clock edge; the next read completes normally.
